// File: rtl/frame_reader_pkg.sv
// Shared constants and FSM encoding for the frame reader and its checksum helper.
package frame_reader_pkg;

   // Frame geometry of the commutator buffer
   localparam int FRAME_WORDS = 18;
   localparam int WORD_W      = 16;
   localparam int ADR_W       = 5;

   // Read sequencer states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RDREQ   = 3'd1,
      RDWAIT  = 3'd2,
      PRESENT = 3'd3,
      CSUM    = 3'd4
   } state_t;

endpackage

// File: rtl/frame_csum.sv
// Running modular sum of data words; cleared at frame start, one add per captured word.
// Carry out of the top bit is discarded, so the result wraps mod 2^DW.
module frame_csum
   import frame_reader_pkg::*;
#(
   parameter int DW = WORD_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          add,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] sum
);

   // Accumulator: clear has priority over add
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (add) begin
         sum <= sum + din;
      end
   end

endmodule

// File: rtl/frame_reader.sv
// Frame reader: on a rising edge of 'full' fetches NWORDS words from the frame RAM,
// streams them over valid/ready and appends the 16-bit wrapping checksum as last beat.
module frame_reader
   import frame_reader_pkg::*;
#(
   parameter int NWORDS = FRAME_WORDS,
   parameter int DW     = WORD_W,
   parameter int AW     = ADR_W,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          full,
   output logic [AW-1:0] rdAdr,
   output logic          rdEn,
   input  logic [DW-1:0] rdData,
   output logic [DW-1:0] outData,
   output logic          outValid,
   input  logic          outReady,
   output logic          outSof,
   output logic          outEof,
   output logic          busy,
   output logic          frameDone,
   output logic          overrun,
   input  logic          clrOvr
);

   // Last latency count before capture, and last word index of a frame
   localparam logic [1:0]    LAT_LAST = 2'(RD_LAT - 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(NWORDS - 1);

   state_t        state_reg, state_next;
   logic [AW-1:0] idx_reg, idx_next;
   logic [1:0]    lat_reg, lat_next;
   logic          full_d_reg;
   logic [DW-1:0] out_data_reg, out_data_next;
   logic          out_valid_reg, out_valid_next;
   logic          out_sof_reg, out_sof_next;
   logic          out_eof_reg, out_eof_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          ovr_reg, ovr_next;

   logic          start;
   logic          accept;
   logic          csum_clr;
   logic          csum_add;
   logic [DW-1:0] sum;

   // Edge detect: a level held high must not retrigger a frame
   assign start  = full & ~full_d_reg;
   assign accept = out_valid_reg & outReady;

   frame_csum #(
      .DW (DW)
   ) u_csum (
      .clk (clk),
      .rst (rst),
      .clr (csum_clr),
      .add (csum_add),
      .din (rdData),
      .sum (sum)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and next-output logic for the read/present sequence
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      lat_next       = lat_reg;
      out_data_next  = out_data_reg;
      out_valid_next = out_valid_reg;
      out_sof_next   = out_sof_reg;
      out_eof_next   = out_eof_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      ovr_next       = ovr_reg;
      csum_clr       = 1'b0;
      csum_add       = 1'b0;

      case (state_reg)
         IDLE: begin
            // A start coinciding with the frameDone pulse is treated as overrun
            if (start && !done_reg) begin
               state_next = RDREQ;
               idx_next   = '0;
               csum_clr   = 1'b1;
               busy_next  = 1'b1;
            end
         end
         RDREQ: begin
            lat_next   = '0;
            state_next = RDWAIT;
         end
         RDWAIT: begin
            if (lat_reg == LAT_LAST) begin
               out_data_next  = rdData;
               out_valid_next = 1'b1;
               out_sof_next   = (idx_reg == '0);
               csum_add       = 1'b1;
               state_next     = PRESENT;
            end else begin
               lat_next = lat_reg + 2'd1;
            end
         end
         PRESENT: begin
            if (accept) begin
               out_valid_next = 1'b0;
               out_sof_next   = 1'b0;
               if (idx_reg == LAST_IDX) begin
                  // sum already includes the word just accepted
                  out_data_next  = sum;
                  out_valid_next = 1'b1;
                  out_eof_next   = 1'b1;
                  state_next     = CSUM;
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = RDREQ;
               end
            end
         end
         CSUM: begin
            if (accept) begin
               out_valid_next = 1'b0;
               out_eof_next   = 1'b0;
               busy_next      = 1'b0;
               done_next      = 1'b1;
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Overrun is sticky; a new edge while occupied beats a simultaneous clear
      if (start && (busy_reg || done_reg)) begin
         ovr_next = 1'b1;
      end else if (clrOvr) begin
         ovr_next = 1'b0;
      end
   end

   // Datapath and flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg       <= '0;
         lat_reg       <= '0;
         full_d_reg    <= 1'b0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_sof_reg   <= 1'b0;
         out_eof_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         ovr_reg       <= 1'b0;
      end else begin
         idx_reg       <= idx_next;
         lat_reg       <= lat_next;
         full_d_reg    <= full;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
         out_sof_reg   <= out_sof_next;
         out_eof_reg   <= out_eof_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         ovr_reg       <= ovr_next;
      end
   end

   // idx only changes right before a read request, so it doubles as the held address
   assign rdAdr     = idx_reg;
   assign rdEn      = (state_reg == RDREQ);
   assign outData   = out_data_reg;
   assign outValid  = out_valid_reg;
   assign outSof    = out_sof_reg;
   assign outEof    = out_eof_reg;
   assign busy      = busy_reg;
   assign frameDone = done_reg;
   assign overrun   = ovr_reg;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: one RD_LAT=1 and one RD_LAT=3 instance share a RAM model,
// 'full', 'rst' and 'clrOvr'; frames are checked beat by beat against a table.
module tb_frame_reader;

   localparam int MAX_CYC = 400;

   typedef struct packed {
      logic        sof;
      logic        eof;
      logic [15:0] data;
   } beat_t;

   typedef struct {
      int          fill;
      int          ready_mode;
      logic [15:0] exp_csum;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        full;
   logic        clr_ovr;
   logic        ready1, ready3;

   logic [4:0]  rd_adr1, rd_adr3;
   logic        rd_en1, rd_en3;
   logic [15:0] rd_data1, rd_data3;
   logic [15:0] out_data1, out_data3;
   logic        out_valid1, out_valid3;
   logic        out_sof1, out_sof3;
   logic        out_eof1, out_eof3;
   logic        busy1, busy3;
   logic        frame_done1, frame_done3;
   logic        overrun1, overrun3;

   logic [15:0] ram [0:31];
   logic [15:0] p1_1;
   logic [15:0] p3_1, p3_2, p3_3;

   int n_checks, n_pass;
   beat_t q1[$];
   beat_t q3[$];
   int done1, done3, done_cyc1, done_cyc3;
   int first_en1, first_v1, first_en3, first_v3, en_after_done1;
   logic [4:0] first_adr1;
   vec_t vecs[5];
   bit to;

   frame_reader #(.RD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .full(full),
      .rdAdr(rd_adr1), .rdEn(rd_en1), .rdData(rd_data1),
      .outData(out_data1), .outValid(out_valid1), .outReady(ready1),
      .outSof(out_sof1), .outEof(out_eof1), .busy(busy1),
      .frameDone(frame_done1), .overrun(overrun1), .clrOvr(clr_ovr)
   );

   frame_reader #(.RD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .full(full),
      .rdAdr(rd_adr3), .rdEn(rd_en3), .rdData(rd_data3),
      .outData(out_data3), .outValid(out_valid3), .outReady(ready3),
      .outSof(out_sof3), .outEof(out_eof3), .busy(busy3),
      .frameDone(frame_done3), .overrun(overrun3), .clrOvr(clr_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model, 1-cycle read for instance 1
   always @(posedge clk) begin
      if (rd_en1) p1_1 <= ram[rd_adr1];
   end
   assign rd_data1 = p1_1;

   // RAM model, 3-cycle read for instance 3
   always @(posedge clk) begin
      if (rd_en3) p3_1 <= ram[rd_adr3];
      p3_2 <= p3_1;
      p3_3 <= p3_2;
   end
   assign rd_data3 = p3_3;

   function automatic logic [15:0] fill_val(input int mode, input int i);
      case (mode)
         0: return 16'(i + 1);
         1: return 16'hFFFF;
         2: return 16'((i + 1) << 12);
         default: return 16'h8000;
      endcase
   endfunction

   function automatic logic [31:0] snap1();
      return 32'({out_valid1, out_sof1, out_eof1, out_data1});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " outputs1"}, 32'({rd_adr1, rd_en1, out_data1, out_valid1, out_sof1,
                                    out_eof1, busy1, frame_done1, overrun1}), 32'd0);
      check({tag, " outputs3"}, 32'({rd_adr3, rd_en3, out_data3, out_valid3, out_sof3,
                                    out_eof3, busy3, frame_done3, overrun3}), 32'd0);
   endtask

   task automatic fill_ram(input int mode);
      for (int i = 0; i < 32; i++) ram[i] = (i < 18) ? fill_val(mode, i) : 16'hDEAD;
   endtask

   task automatic start_frame();
      @(negedge clk);
      full = 1'b0;
      @(negedge clk);
      full = 1'b1;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
   endtask

   // Runs one frame on both instances, recording accepted beats and events
   task automatic run_frame(input int ready_mode, input int full_beat, input int rst_beat,
                            input bit full_on_done, output bit timed_out);
      bit          stall1;
      logic [31:0] hold1;
      int          inj;
      q1.delete();
      q3.delete();
      done1 = 0; done3 = 0; done_cyc1 = -1; done_cyc3 = -1;
      first_en1 = -1; first_v1 = -1; first_en3 = -1; first_v3 = -1;
      first_adr1 = '0; en_after_done1 = 0;
      stall1 = 1'b0; hold1 = '0; inj = 0; timed_out = 1'b1;
      for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
         @(negedge clk);
         if (cyc == 0) full = 1'b0;
         if (inj == 1) begin
            full = 1'b0;
            clr_ovr = 1'b0;
            inj = 2;
         end
         if (rd_en1) begin
            if (first_en1 < 0) begin
               first_en1 = cyc;
               first_adr1 = rd_adr1;
            end
            if (done1 > 0) en_after_done1++;
         end
         if (rd_en3 && first_en3 < 0) first_en3 = cyc;
         if (out_valid1 && first_v1 < 0) first_v1 = cyc;
         if (out_valid3 && first_v3 < 0) first_v3 = cyc;
         if (frame_done1) begin
            done1++;
            if (done_cyc1 < 0) done_cyc1 = cyc;
         end
         if (frame_done3) begin
            done3++;
            if (done_cyc3 < 0) done_cyc3 = cyc;
         end
         if (stall1) check($sformatf("stall_hold beat%0d", q1.size()), snap1(), hold1);
         ready1 = (ready_mode == 0) || ((cyc % 4) == 0);
         if (out_valid1 && ready1) begin
            q1.push_back({out_sof1, out_eof1, out_data1});
            stall1 = 1'b0;
         end else begin
            stall1 = out_valid1;
            hold1 = snap1();
         end
         if (out_valid3 && ready3) q3.push_back({out_sof3, out_eof3, out_data3});
         if (full_beat >= 0 && inj == 0 && q1.size() == full_beat) begin
            full = 1'b1;
            clr_ovr = 1'b1;
            inj = 1;
         end
         if (full_on_done && frame_done1) full = 1'b1;
         if (rst_beat >= 0 && q1.size() == rst_beat) begin
            rst = 1'b1;
            @(negedge clk);
            check_idle("mid_frame_rst");
            check("rst_no_done", 32'(done1), 32'd0);
            rst = 1'b0;
            timed_out = 1'b0;
            break;
         end
         if (done1 > 0 && done3 > 0) begin
            timed_out = 1'b0;
            break;
         end
      end
      ready1 = 1'b1;
   endtask

   // Compares recorded beats of both instances against the RAM model and checksum
   task automatic verify(input string tag, input int fill, input logic [15:0] csum);
      check({tag, " beats1"}, 32'(q1.size()), 32'd19);
      check({tag, " beats3"}, 32'(q3.size()), 32'd19);
      for (int k = 0; k < 19; k++) begin
         logic [15:0] ed;
         logic [1:0]  ef;
         ed = (k < 18) ? fill_val(fill, k) : csum;
         ef = {k == 0, k == 18};
         if (k < q1.size())
            check($sformatf("%s inst1 beat%0d {sof,eof,data}", tag, k), 32'(q1[k]), 32'({ef, ed}));
         if (k < q3.size())
            check($sformatf("%s inst3 beat%0d {sof,eof,data}", tag, k), 32'(q3[k]), 32'({ef, ed}));
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      rst = 1'b1;
      full = 1'b0;
      clr_ovr = 1'b0;
      ready1 = 1'b1;
      ready3 = 1'b1;
      fill_ram(0);

      // Reset state
      repeat (3) @(negedge clk);
      check_idle("in_reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_reset");

      // Table-driven frames: fill pattern, ready pattern, hand-computed checksum
      vecs[0] = '{fill: 0, ready_mode: 0, exp_csum: 16'h00AB};
      vecs[1] = '{fill: 0, ready_mode: 1, exp_csum: 16'h00AB};
      vecs[2] = '{fill: 1, ready_mode: 0, exp_csum: 16'hFFEE};
      vecs[3] = '{fill: 2, ready_mode: 1, exp_csum: 16'hB000};
      vecs[4] = '{fill: 3, ready_mode: 0, exp_csum: 16'h0000};

      for (int v = 0; v < 5; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         fill_ram(vecs[v].fill);
         start_frame();
         run_frame(vecs[v].ready_mode, -1, -1, 1'b0, to);
         check({tag, " timeout"}, 32'(to), 32'd0);
         verify(tag, vecs[v].fill, vecs[v].exp_csum);
         check({tag, " done_pulses1"}, 32'(done1), 32'd1);
         check({tag, " done_pulses3"}, 32'(done3), 32'd1);
         check({tag, " busy_low"}, 32'({busy1, busy3}), 32'd0);
         check({tag, " no_overrun"}, 32'({overrun1, overrun3}), 32'd0);
         check({tag, " first_adr"}, 32'(first_adr1), 32'd0);
         check({tag, " done_cyc3"}, 32'(done_cyc3), 32'd91);
         if (vecs[v].ready_mode == 0) begin
            check({tag, " rd_to_valid1"}, 32'(first_v1 - first_en1), 32'd2);
            check({tag, " rd_to_valid3"}, 32'(first_v3 - first_en3), 32'd4);
            check({tag, " done_cyc1"}, 32'(done_cyc1), 32'd55);
         end
      end

      // Second full edge at beat 5 together with clrOvr: frame intact, overrun set
      fill_ram(0);
      start_frame();
      run_frame(0, 5, -1, 1'b0, to);
      check("ovr timeout", 32'(to), 32'd0);
      verify("ovr", 0, 16'h00AB);
      check("ovr done_pulses1", 32'(done1), 32'd1);
      check("ovr set", 32'({overrun1, overrun3}), 32'b11);
      pulse_clr();
      check("ovr cleared", 32'({overrun1, overrun3}), 32'd0);

      // full rises in the frameDone cycle of instance 1: ignored, flagged, held level
      start_frame();
      run_frame(0, -1, -1, 1'b1, to);
      check("fod timeout", 32'(to), 32'd0);
      verify("fod", 0, 16'h00AB);
      check("fod overrun1", 32'(overrun1), 32'd1);
      check("fod busy1", 32'(busy1), 32'd0);
      check("fod reads_after_done", 32'(en_after_done1), 32'd0);
      pulse_clr();

      // Reset at beat 10, then a fresh edge restarts from address 0
      fill_ram(2);
      start_frame();
      run_frame(0, -1, 10, 1'b0, to);
      check("rst path reached", 32'(to), 32'd0);
      start_frame();
      run_frame(0, -1, -1, 1'b0, to);
      check("restart timeout", 32'(to), 32'd0);
      verify("restart", 2, 16'hB000);
      check("restart first_adr", 32'(first_adr1), 32'd0);
      check("restart done_pulses1", 32'(done1), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
